rect_select: RTL
================

# rect_select

Upstream proposal stage for the rectangle-loop flip datapath. Holds the current 4x4 binary matrix and draws candidate rectangles (r1, r2, c1, c2) from an internal LFSR. It rejects any candidate whose four corners do not form a flippable checkerboard, and offers accepted candidates to the combinational flip stage over a valid/ready handshake. On each accepted handshake it registers the flipped matrix returned by that stage, and repeats until a requested number of flips has been applied.

## Interface
- ROWS, 4: matrix rows; fixed at 4 because coordinates are 2 bits.
- COLS, 4: matrix columns; fixed at 4.
- SEED, 16'hACE1: LFSR reset value; must be nonzero.
- MAX_TRIES, 15: consecutive rejected candidates allowed per step before giving up; range 1..255.
- clk  in  1  single clock, rising edge.
- rst_n  in  1  synchronous, active-low reset.
- start  in  1  begin a run; sampled only in IDLE.
- m_in  in  16  initial matrix, captured on start.
- steps  in  8  number of flips to apply in this run.
- m_fb  in  16  flipped matrix from the flip stage; a combinational function of m_cur and the coordinates.
- cand_ready  in  1  flip stage/consumer accepts the current candidate.
- m_cur  out  16  current matrix; drives the flip stage m_in.
- r1, r2, c1, c2  out  2 each  candidate coordinates.
- cand_valid  out  1  candidate is valid and stable.
- busy  out  1  high whenever state is not IDLE.
- done  out  1  one-cycle completion pulse.
- stuck  out  1  last run ended on MAX_TRIES; held until next start.
- attempts  out  16  candidates drawn this run; saturates at 16'hFFFF.

## Operation
- Bit mapping: element (r,c) is bit 15-(c*ROWS+r), i.e. column-major with (0,0) at the MSB. This mapping is shared with the flip stage.
- LFSR: 16-bit Galois, right shift, mask 16'hB400.
  - Next value = (lfsr>>1) ^ (lfsr[0] ? 16'hB400 : 0).
  - Advances only in GEN.
  - Not reseeded on start.
- Coordinate extraction from the new LFSR value: r1=[1:0], r2=[3:2], c1=[5:4], c2=[7:6].
- Candidate acceptance:
  - r1!=r2 and c1!=c2.
  - a=(r1,c1), b=(r1,c2), c=(r2,c1), d=(r2,c2) satisfy a==d, b==c, a!=b.
  - This preserves all row and column sums.
- States:
  - IDLE:
    - If start: capture m_in into m_cur and steps into steps_left.
    - Clear attempts, tries and stuck.
    - If steps==0, go to DONE; else go to GEN.
  - GEN:
    - Advance the LFSR, register the coordinates, increment attempts (saturating).
    - Go to CHECK.
  - CHECK:
    - Evaluate the candidate against m_cur.
    - Pass: clear tries, go to OFFER.
    - Fail: tries+1. If tries+1==MAX_TRIES, set stuck and go to DONE; else go to GEN.
  - OFFER:
    - cand_valid=1; the coordinates and m_cur are held stable.
    - On cand_valid && cand_ready: m_cur<=m_fb and steps_left-1.
    - If steps_left was 1, go to DONE; else go to GEN.
  - DONE: done=1 for this cycle, then IDLE. m_cur retains the final matrix.
- start outside IDLE is ignored.
- Reset values:
  - State IDLE, m_cur=0, coordinates 0, lfsr=SEED.
  - cand_valid, busy, done and stuck all 0; attempts=0; tries=0.

## Timing
- start high in cycle t gives GEN in t+1, CHECK in t+2, and the earliest cand_valid in t+3.
- Each rejection costs 2 cycles (GEN + CHECK).
- Handshake:
  - cand_valid never drops without a handshake, except on reset.
  - cand_ready may be low indefinitely; outputs hold with no LFSR advance.
  - cand_ready high before cand_valid has no effect.
- The handshake cycle is the last OFFER cycle. The next cycle is GEN (more steps remain) or DONE.
- rst_n low at any edge overrides everything: reset values appear on the next cycle and any in-flight candidate is dropped.
- No combinational path from inputs to outputs.

## Test plan
- Seeded run: reset, m_in=16'h2008, steps=1, start at t, flip stage connected, cand_ready=1.
  - First draw (lfsr 16'hE270) is rejected (r1==r2).
  - Second draw (lfsr 16'h7138) gives cand_valid at t+5 with r1=0, r2=2, c1=3, c2=0.
  - m_cur=16'h8002 at t+6, done at t+6, attempts=2, stuck=0.
- Zero steps: steps=0 with start -> done on the cycle after start, attempts=0, LFSR unchanged, m_cur=m_in.
- Unflippable matrix: m_in=16'h0000, steps=3, MAX_TRIES=15 -> no cand_valid, done at t+31, stuck=1, attempts=15, m_cur=0.
- Backpressure: hold cand_ready=0 for 10 cycles during OFFER.
  - cand_valid, coordinates and m_cur stay constant; no LFSR advance.
  - Release -> single update and run completes.
- Multi-step invariant: m_in=16'hA5A5, steps=50, cand_ready random -> done with stuck=0 and row/column popcounts of m_cur equal to those of m_in.
  - Scoreboard every handshake against the checkerboard rule.
- Reset mid-OFFER: drive rst_n=0 while cand_valid=1 -> next cycle all outputs at reset values, state IDLE. A fresh start reproduces the seeded-run sequence.

Source files
------------

// File: rtl/rect_select.sv
// rect_select: draws LFSR rectangle candidates over a 4x4 binary matrix, keeps only
// flippable checkerboard corners, and offers them to the flip stage over valid/ready.
module rect_select #(
    parameter int ROWS = 4,
    parameter int COLS = 4,
    parameter logic [15:0] SEED = 16'hACE1,
    parameter int MAX_TRIES = 15
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [15:0] m_in,
    input  logic [7:0]  steps,
    input  logic [15:0] m_fb,
    input  logic        cand_ready,
    output logic [15:0] m_cur,
    output logic [1:0]  r1,
    output logic [1:0]  r2,
    output logic [1:0]  c1,
    output logic [1:0]  c2,
    output logic        cand_valid,
    output logic        busy,
    output logic        done,
    output logic        stuck,
    output logic [15:0] attempts
);
    localparam int N = ROWS * COLS;
    localparam logic [2:0] IDLE = 3'd0, GEN = 3'd1, CHECK = 3'd2, OFFER = 3'd3, DONE = 3'd4;
    localparam logic [7:0] TRY_LIMIT = 8'(MAX_TRIES);

    logic [2:0]  state;
    logic [15:0] lfsr, lfsr_next;
    logic [7:0]  steps_left, tries, tries_inc;
    logic        ca, cb, cc, cd, pass, give_up;

    // Column-major with (0,0) at the MSB, matching the flip stage.
    function automatic logic at(input logic [15:0] m, input logic [1:0] r, input logic [1:0] c);
        return m[4'(N - 1 - (int'(c) * ROWS + int'(r)))];
    endfunction

    always_comb begin
        lfsr_next = {1'b0, lfsr[15:1]} ^ (lfsr[0] ? 16'hB400 : 16'h0000);
        ca = at(m_cur, r1, c1);
        cb = at(m_cur, r1, c2);
        cc = at(m_cur, r2, c1);
        cd = at(m_cur, r2, c2);
        pass = (r1 != r2) && (c1 != c2) && (ca == cd) && (cb == cc) && (ca != cb);
        tries_inc = tries + 8'd1;
        give_up = !pass && (tries_inc == TRY_LIMIT);
    end

    assign cand_valid = state == OFFER;
    assign busy = state != IDLE;
    assign done = state == DONE;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
            m_cur <= '0;
            {r1, r2, c1, c2} <= '0;
            lfsr <= SEED;
            steps_left <= '0;
            tries <= '0;
            stuck <= 1'b0;
            attempts <= '0;
        end else begin
            case (state)
                IDLE: if (start) begin
                    m_cur <= m_in;
                    steps_left <= steps;
                    attempts <= '0;
                    tries <= '0;
                    stuck <= 1'b0;
                    state <= (steps == 8'd0) ? DONE : GEN;
                end
                GEN: begin
                    lfsr <= lfsr_next;
                    {c2, c1, r2, r1} <= lfsr_next[7:0];
                    attempts <= attempts + {15'd0, attempts != 16'hFFFF};
                    state <= CHECK;
                end
                CHECK: begin
                    tries <= pass ? 8'd0 : tries_inc;
                    stuck <= give_up;
                    state <= pass ? OFFER : (give_up ? DONE : GEN);
                end
                OFFER: if (cand_ready) begin
                    m_cur <= m_fb;
                    steps_left <= steps_left - 8'd1;
                    state <= (steps_left == 8'd1) ? DONE : GEN;
                end
                DONE: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule
